btn_onehot_debounce: RTL and testbench

BTN_ONEHOT_DEBOUNCE -- requirements
Module: btn_onehot_debounce

---
 rtl/btn_onehot_debounce_pkg.sv | 30 +++
 rtl/debounce_bit.sv | 49 ++++
 rtl/btn_onehot_debounce.sv | 67 ++++++
 tb/tb_btn_onehot_debounce.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_onehot_debounce_pkg.sv
// Shared constants and the one-hot classifier for the button debouncer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package btn_onehot_debounce_pkg;

  localparam int BTN_W               = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  // How many debounced buttons are down: none, exactly one, or several.
  typedef enum logic [1:0] {
    CODE_NONE  = 2'd0,
    CODE_ONE   = 2'd1,
    CODE_MULTI = 2'd2
  } code_kind_e;

  function automatic code_kind_e classify(input logic [BTN_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < BTN_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    if (n == 0) begin
      return CODE_NONE;
    end else if (n == 1) begin
      return CODE_ONE;
    end
    return CODE_MULTI;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchronizer plus saturating agreement counter for one button bit.
// Latency: a steady raw level reaches s DEBOUNCE_CYCLES+1 edges after first being sampled.
// Backpressure: none; free-running, s is a level.
module debounce_bit
  import btn_onehot_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic s
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button level into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has disagreed with s for DEBOUNCE_CYCLES
  // consecutive cycles; any agreement restarts the count, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s   <= 1'b0;
      cnt <= '0;
    end else if (sync2 == s) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      s   <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/btn_onehot_debounce.sv
// Debounces BTN_W buttons and presents a registered one-hot code, enable, press pulse and multi flag.
// Latency: steady raw level sampled at edge k shows on a/en/multi/press at edge k+2+DEBOUNCE_CYCLES.
// Backpressure: none; outputs are levels except press, a single-cycle pulse that is not held.
module btn_onehot_debounce
  import btn_onehot_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BTN_W-1:0] btn,
  output logic [BTN_W-1:0] a,
  output logic             en,
  output logic             press,
  output logic             multi
);

  logic [BTN_W-1:0] s;
  logic [BTN_W-1:0] a_nxt;
  logic             en_nxt;
  logic             multi_nxt;
  logic             press_nxt;

  for (genvar i = 0; i < BTN_W; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .raw (btn[i]),
      .s   (s[i])
    );
  end

  // Decode the debounced vector; press fires when a new valid code appears,
  // including a direct switch from one button to another.
  always_comb begin
    a_nxt     = '0;
    en_nxt    = 1'b0;
    multi_nxt = 1'b0;
    unique case (classify(s))
      CODE_ONE: begin
        a_nxt  = s;
        en_nxt = 1'b1;
      end
      CODE_MULTI: multi_nxt = 1'b1;
      default:    ;
    endcase
    press_nxt = en_nxt && (!en || (a_nxt != a));
  end

  // Register the decoded outputs so the downstream encoder sees clean levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= '0;
      en    <= 1'b0;
      press <= 1'b0;
      multi <= 1'b0;
    end else begin
      a     <= a_nxt;
      en    <= en_nxt;
      press <= press_nxt;
      multi <= multi_nxt;
    end
  end

endmodule

// File: tb/tb_btn_onehot_debounce.sv
// Directed bench for btn_onehot_debounce with a window-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_btn_onehot_debounce;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [3:0] a;
  logic       en;
  logic       press;
  logic       multi;

  always #5 clk = ~clk;

  btn_onehot_debounce #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .a     (a),
    .en    (en),
    .press (press),
    .multi (multi)
  );

  int n_cmp  = 0;
  int n_bad  = 0;
  int npress = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream 4-to-2 encoder fed by a with en as enable.
  function automatic logic [1:0] enc(input logic [3:0] v, input logic e);
    if (!e) return 2'd0;
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Reference model: a bit's stable value flips when the synchronized input
  // has shown the opposite level for each of the last D cycles.
  logic [3:0] m_sync1, m_sync2, m_s, m_a;
  logic       m_en, m_press, m_multi;
  logic [3:0] win[$];

  always @(posedge clk or posedge rst) begin : model
    logic [3:0] s_old;
    logic [3:0] a_new;
    logic       en_new;
    logic       all_diff;
    int         pop;
    if (rst) begin
      m_sync1 = '0; m_sync2 = '0; m_s = '0; m_a = '0;
      m_en = 1'b0; m_press = 1'b0; m_multi = 1'b0;
      win.delete();
    end else begin
      win.push_back(m_sync2);
      if (win.size() > D) void'(win.pop_front());
      s_old = m_s;
      for (int i = 0; i < 4; i++) begin
        all_diff = (win.size() == D);
        for (int j = 0; j < win.size(); j++)
          if (win[j][i] == s_old[i]) all_diff = 1'b0;
        if (all_diff) m_s[i] = ~s_old[i];
      end
      pop     = $countones(s_old);
      en_new  = (pop == 1);
      a_new   = en_new ? s_old : 4'b0000;
      m_press = en_new && (!m_en || (a_new != m_a));
      m_a     = a_new;
      m_en    = en_new;
      m_multi = (pop >= 2);
      m_sync2 = m_sync1;
      m_sync1 = btn;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_a", {28'd0, a}, {28'd0, m_a});
    check("model_en", {31'd0, en}, {31'd0, m_en});
    check("model_press", {31'd0, press}, {31'd0, m_press});
    check("model_multi", {31'd0, multi}, {31'd0, m_multi});
    if (press) npress++;
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    btn = v;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int         p0;
    logic [3:0] v;

    // Reset takes effect with no clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_a", {28'd0, a}, 32'h0);
    check("rst_en", {31'd0, en}, 32'h0);
    check("rst_press", {31'd0, press}, 32'h0);
    check("rst_multi", {31'd0, multi}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single button, full latency, one press.
    p0 = npress;
    drive(4'b0100);
    edges(6);
    check("s1_en_k5", {31'd0, en}, 32'h0);
    edges(1);
    check("s1_a_k6", {28'd0, a}, 32'h4);
    check("s1_en_k6", {31'd0, en}, 32'h1);
    check("s1_press_k6", {31'd0, press}, 32'h1);
    check("s1_model_a_pin", {28'd0, m_a}, 32'h4);
    edges(1);
    check("s1_press_k7", {31'd0, press}, 32'h0);
    check("s1_npress", npress - p0, 32'h1);

    // Short 3-cycle pulse is rejected.
    drive(4'b0000);
    edges(8);
    check("s2_a_idle", {28'd0, a}, 32'h0);
    p0 = npress;
    drive(4'b0010);
    @(negedge clk);
    @(negedge clk);
    drive(4'b0000);
    edges(10);
    check("s2_no_press", npress - p0, 32'h0);
    check("s2_en", {31'd0, en}, 32'h0);

    // Second button turns the code into multi, releasing it returns a press.
    drive(4'b0001);
    edges(8);
    check("s3_a_one", {28'd0, a}, 32'h1);
    drive(4'b0011);
    edges(6);
    check("s3_multi_k5", {31'd0, multi}, 32'h0);
    check("s3_en_k5", {31'd0, en}, 32'h1);
    edges(1);
    check("s3_multi_k6", {31'd0, multi}, 32'h1);
    check("s3_en_k6", {31'd0, en}, 32'h0);
    check("s3_a_k6", {28'd0, a}, 32'h0);
    check("s3_model_multi_pin", {31'd0, m_multi}, 32'h1);
    p0 = npress;
    drive(4'b0001);
    edges(6);
    check("s3_en_back_k5", {31'd0, en}, 32'h0);
    edges(1);
    check("s3_en_back_k6", {31'd0, en}, 32'h1);
    check("s3_a_back", {28'd0, a}, 32'h1);
    check("s3_press_back", {31'd0, press}, 32'h1);
    edges(2);
    check("s3_npress", npress - p0, 32'h1);

    // Reset mid-operation clears everything and forces full latency again.
    drive(4'b1000);
    edges(8);
    check("s4_a_pre", {28'd0, a}, 32'h8);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("s4_rst_a", {28'd0, a}, 32'h0);
    check("s4_rst_en", {31'd0, en}, 32'h0);
    check("s4_rst_press", {31'd0, press}, 32'h0);
    check("s4_rst_multi", {31'd0, multi}, 32'h0);
    p0 = npress;
    @(negedge clk);
    rst = 1'b0;
    edges(6);
    check("s4_en_k5", {31'd0, en}, 32'h0);
    edges(1);
    check("s4_a_k6", {28'd0, a}, 32'h8);
    check("s4_press_k6", {31'd0, press}, 32'h1);
    edges(1);
    check("s4_npress", npress - p0, 32'h1);

    // Toggling every cycle is ignored; a direct switch then yields one press.
    p0 = npress;
    v  = 4'b0111;
    for (int t = 0; t < 20; t++) begin
      drive(v);
      v = ~v;
    end
    drive(4'b0010);
    edges(6);
    check("s5_a_hold", {28'd0, a}, 32'h8);
    check("s5_en_hold", {31'd0, en}, 32'h1);
    check("s5_no_press", npress - p0, 32'h0);
    edges(1);
    check("s5_a_new", {28'd0, a}, 32'h2);
    check("s5_en_new", {31'd0, en}, 32'h1);
    check("s5_press_new", {31'd0, press}, 32'h1);

    // Encoder walk across every single button, then none.
    for (int i = 0; i < 4; i++) begin
      drive(4'(1 << i));
      edges(7);
      check("s6_enc_y", {30'd0, enc(a, en)}, i);
    end
    drive(4'b0000);
    edges(7);
    check("s6_enc_none", {30'd0, enc(a, en)}, 32'h0);
    check("s6_en_none", {31'd0, en}, 32'h0);

    edges(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
